// File: rtl/render_frame_controller.sv
// Per-frame sequencer between scene logic and the renderer: loads one frame of
// triangles, holds the renderer active through a render, then swaps framebuffers.
module render_frame_controller #(
  parameter int MAX_TRIANGLES    = 256,
  parameter int PIXELS_PER_FRAME = 57600,
  parameter int TIMEOUT_CYCLES   = 2000000,
  parameter int SETTLE_CYCLES    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_start,
  input  logic [127:0] tri_in_data,
  input  logic         tri_in_valid,
  input  logic         tri_in_last,
  output logic         tri_in_ready,
  output logic [127:0] rdr_triangle,
  output logic         rdr_triangle_valid,
  output logic         rdr_active,
  input  logic         rdr_valid,
  input  logic         rdr_done,
  output logic         fb_select,
  output logic         fb_swap,
  output logic         frame_done,
  output logic         busy,
  output logic         pixel_error,
  output logic         timeout_error,
  output logic [7:0]   dropped_count,
  output logic [7:0]   missed_frames,
  output logic [15:0]  frame_count
);

  localparam int TCW = $clog2(MAX_TRIANGLES + 1);
  localparam int TMW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [TCW-1:0] TRI_CAP     = TCW'(MAX_TRIANGLES);
  localparam logic [TMW-1:0] TIMER_LAST  = TMW'(TIMEOUT_CYCLES - 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [16:0]    PIX_TARGET  = 17'(PIXELS_PER_FRAME);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RENDER,
    S_SWAP,
    S_SETTLE
  } state_e;

  state_e         state_q;
  logic [TCW-1:0] tri_count_q;
  logic [16:0]    pix_count_q;
  logic [16:0]    pix_count_d;
  logic [TMW-1:0] timer_q;
  logic [SCW-1:0] settle_q;
  logic [127:0]   rdr_triangle_q;
  logic           rdr_triangle_valid_q;
  logic           rdr_active_q;
  logic           fb_select_q;
  logic           fb_swap_q;
  logic           frame_done_q;
  logic           pixel_error_q;
  logic           timeout_error_q;
  logic [7:0]     dropped_q;
  logic [7:0]     missed_q;
  logic [15:0]    frame_count_q;
  logic           accept;

  assign tri_in_ready = (state_q == S_LOAD);
  assign accept       = tri_in_valid && tri_in_ready;

  // Pixel count including this cycle's beat, so a pixel arriving with
  // rdr_done is counted before the frame-size compare.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    pix_count_d = pix_count_q;
    if (rdr_valid && (pix_count_q != '1)) begin
      pix_count_d = pix_count_q + 1'b1;
    end
  end

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q              <= S_IDLE;
      tri_count_q          <= '0;
      pix_count_q          <= '0;
      timer_q              <= '0;
      settle_q             <= '0;
      rdr_triangle_q       <= '0;
      rdr_triangle_valid_q <= 1'b0;
      rdr_active_q         <= 1'b0;
      fb_select_q          <= 1'b0;
      fb_swap_q            <= 1'b0;
      frame_done_q         <= 1'b0;
      pixel_error_q        <= 1'b0;
      timeout_error_q      <= 1'b0;
      dropped_q            <= '0;
      missed_q             <= '0;
      frame_count_q        <= '0;
    end else begin
      rdr_triangle_valid_q <= 1'b0;
      fb_swap_q            <= 1'b0;
      frame_done_q         <= 1'b0;

      if (frame_start && (state_q != S_IDLE) && (missed_q != 8'hFF)) begin
        missed_q <= missed_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            tri_count_q <= '0;
            state_q     <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (accept) begin
            if (tri_count_q < TRI_CAP) begin
              rdr_triangle_q       <= tri_in_data;
              rdr_triangle_valid_q <= 1'b1;
              tri_count_q          <= tri_count_q + 1'b1;
            end else if (dropped_q != 8'hFF) begin
              dropped_q <= dropped_q + 1'b1;
            end
            if (tri_in_last) begin
              state_q <= S_FLUSH;
            end
          end
        end

        // The final triangle strobe is on the renderer port during this cycle.
        S_FLUSH: begin
          rdr_active_q <= 1'b1;
          pix_count_q  <= '0;
          timer_q      <= '0;
          state_q      <= S_RENDER;
        end

        S_RENDER: begin
          pix_count_q <= pix_count_d;
          timer_q     <= timer_q + 1'b1;
          // Swap outputs are registered on entry so they are visible during SWAP,
          // one cycle after rdr_done; done takes priority over the timeout.
          if (rdr_done) begin
            if (pix_count_d != PIX_TARGET) begin
              pixel_error_q <= 1'b1;
            end
            rdr_active_q  <= 1'b0;
            fb_select_q   <= ~fb_select_q;
            fb_swap_q     <= 1'b1;
            frame_done_q  <= 1'b1;
            frame_count_q <= frame_count_q + 1'b1;
            state_q       <= S_SWAP;
          end else if (timer_q == TIMER_LAST) begin
            timeout_error_q <= 1'b1;
            rdr_active_q    <= 1'b0;
            settle_q        <= '0;
            state_q         <= S_SETTLE;
          end
        end

        S_SWAP: begin
          settle_q <= '0;
          state_q  <= S_SETTLE;
        end

        // Gives the renderer time to walk DONE -> RST -> IDLE before the next load.
        S_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_q <= S_IDLE;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rdr_triangle       = rdr_triangle_q;
  assign rdr_triangle_valid = rdr_triangle_valid_q;
  assign rdr_active         = rdr_active_q;
  assign fb_select          = fb_select_q;
  assign fb_swap            = fb_swap_q;
  assign frame_done         = frame_done_q;
  assign busy               = (state_q != S_IDLE);
  assign pixel_error        = pixel_error_q;
  assign timeout_error      = timeout_error_q;
  assign dropped_count      = dropped_q;
  assign missed_frames      = missed_q;
  assign frame_count        = frame_count_q;

endmodule

// File: doc/render_frame_controller.md
# render_frame_controller

Per-frame sequencer that sits between the game/scene logic and `renderer`. It accepts one frame's triangle stream over a valid/ready handshake and forwards it to the renderer's load port, capping the count at MAX_TRIANGLES. It then drives the renderer's `active` level through a full render, counts output pixels, and enforces the post-done settle time. It finally swaps the double-buffered framebuffer select for the DRAM writer and display reader.

## Interface

Parameters:
- MAX_TRIANGLES, 256: triangle capacity of the renderer; excess triangles are dropped.
- PIXELS_PER_FRAME, 57600: expected `rdr_valid` beats per frame (320 x 180).
- TIMEOUT_CYCLES, 2000000: maximum RENDER duration before abort.
- SETTLE_CYCLES, 4: idle cycles after `rdr_active` falls before the next load.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- frame_start  in  1  single-cycle request to render a new frame
- tri_in_data  in  128  triangle word
- tri_in_valid  in  1  triangle word valid
- tri_in_last  in  1  marks the final triangle of the frame
- tri_in_ready  out  1  high exactly while state == LOAD
- rdr_triangle  out  128  registered triangle to renderer
- rdr_triangle_valid  out  1  registered write strobe to renderer
- rdr_active  out  1  renderer active level
- rdr_valid  in  1  renderer pixel-output strobe
- rdr_done  in  1  renderer done
- fb_select  out  1  framebuffer index currently being rendered into
- fb_swap  out  1  one-cycle pulse when fb_select toggles
- frame_done  out  1  one-cycle pulse at end of frame
- busy  out  1  state != IDLE
- pixel_error  out  1  sticky: a frame ended with pixel count != PIXELS_PER_FRAME
- timeout_error  out  1  sticky: a RENDER timed out
- dropped_count  out  8  saturating count of triangles dropped over capacity
- missed_frames  out  8  saturating count of frame_start pulses ignored while busy
- frame_count  out  16  completed frames, wraps

## Operation

States: IDLE, LOAD, FLUSH, RENDER, SWAP, SETTLE.

- **IDLE**
  - On frame_start: go to LOAD and clear tri_count.
- **LOAD**
  - Accept = tri_in_valid & tri_in_ready.
  - Each accept with tri_count < MAX_TRIANGLES: next cycle rdr_triangle = tri_in_data, rdr_triangle_valid = 1, tri_count++.
  - Accept with tri_count == MAX_TRIANGLES: word discarded, dropped_count++ (saturating at 255).
  - Accept with tri_in_last: go to FLUSH. The word is still forwarded or dropped per the rules above.
- **FLUSH**
  - Single cycle in which the last triangle strobe is presented. Go to RENDER.
  - Entering RENDER: rdr_active <= 1, pix_count <= 0, timer <= 0.
- **RENDER**
  - rdr_active held high. pix_count (17 bits, saturating) increments on each rdr_valid. timer++.
  - On rdr_done: pixel_error |= (pix_count != PIXELS_PER_FRAME). Go to SWAP.
  - On timer == TIMEOUT_CYCLES - 1 without rdr_done: timeout_error <= 1, rdr_active <= 0, go to SETTLE. No swap, no frame_done, frame_count unchanged.
- **SWAP**
  - rdr_active <= 0; fb_select toggles; fb_swap and frame_done pulse; frame_count++. Go to SETTLE.
- **SETTLE**
  - Count SETTLE_CYCLES, then go to IDLE. This guarantees the renderer has passed DONE -> RST -> IDLE and cleared its triangle count.

General rules:
- frame_start in any state other than IDLE is ignored and increments missed_frames (saturating).
- A zero-triangle frame (no valid word before tri_in_last) cannot occur, because the last flag travels with a word. A lone tri_in_last word still counts as a triangle.
- Sticky errors clear only on rst. dropped_count and missed_frames clear only on rst.

## Timing

- Reset: all outputs 0, including fb_select = 0 and all counters 0. State = IDLE.
- Reset mid-operation forces IDLE in the next cycle with rdr_active = 0 and rdr_triangle_valid = 0.
- Triangle forwarding latency: 1 cycle from accept to rdr_triangle_valid. Throughput is 1 triangle per cycle.
- rdr_active rises 2 cycles after the tri_in_last accept (one cycle in FLUSH, then RENDER).
- rdr_valid and rdr_done arriving in the same cycle: that pixel is counted before the compare.
- rdr_done and timeout in the same cycle: rdr_done wins.
- fb_swap, frame_done and the fb_select toggle occur together, 1 cycle after rdr_done.
- Minimum gap from frame_done to the next LOAD is SETTLE_CYCLES + 1 cycles.
- rdr_valid outside RENDER is ignored.

## Test plan

- **Normal frame.** frame_start, then 3 triangles (last on the 3rd). Model renderer emits 57600 rdr_valid, then rdr_done.
  - Required: 3 rdr_triangle_valid beats with matching data.
  - Required: rdr_active rises 2 cycles after the last accept and falls 1 cycle after done.
  - Required: fb_select 0->1, frame_count = 1, pixel_error = 0.
- **Overflow.** 258 triangles streamed.
  - Required: exactly 256 forwarded, dropped_count = 2.
  - Required: tri_in_ready stays high until the last word.
- **Busy frame_start.** frame_start pulses in LOAD, RENDER and SETTLE.
  - Required: missed_frames = 3; only one frame rendered.
- **Short pixel count.** Model emits 57599 pixels, then done.
  - Required: pixel_error = 1 (sticky); swap still occurs.
- **Timeout.** TIMEOUT_CYCLES = 100; done never asserted.
  - Required: timeout_error = 1, rdr_active low after 100 RENDER cycles.
  - Required: no fb_swap, frame_count unchanged, IDLE after SETTLE.
- **Reset mid-render.** rst during RENDER.
  - Required: next cycle rdr_active = 0, busy = 0, fb_select = 0, all counters 0.
  - Required: a following frame completes normally.
